// File: rtl/ppl_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package ppl_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC           = 32'hFFFF_FFFC;
  localparam logic [31:0] EXC_VEC_DEF        = 32'h0000_0180;
  localparam logic [31:0] PC_STEP            = 32'd4;
  localparam int          TIMEOUT_CYCLES_DEF = 16;

  // Sequential successor, wrapping modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/ppl_fetch_ctrl_if.sv
// Instruction-memory request/response port between the fetch sequencer and imem.
interface ppl_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ppl_fetch_ctrl_buf.sv
// One-entry {inst, pc} hold buffer used while decode stalls; clear wins over load.
module ppl_fetch_buf
  import ppl_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  logic        valid_reg;
  logic [31:0] inst_reg;
  logic [31:0] pc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      inst_reg  <= '0;
      pc_reg    <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      inst_reg  <= inst_in;
      pc_reg    <= pc_in;
    end
  end

  assign valid = valid_reg;
  assign inst  = inst_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/ppl_fetch_ctrl.sv
// Fetch-stage sequencer: next-PC select, imem handshake, stall buffering, wrong-path kill.
// Optional imem wait timeout enabled by defining FETCH_TIMEOUT_EN.
module ppl_fetch_ctrl
  import ppl_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             pc_cur,
  output logic [31:0]             pc_next,
  output logic                    pc_continue,
  input  logic                    stall_d,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  input  logic                    exc_valid,
  ppl_fetch_ctrl_if.master        imem,
  output logic                    if_valid,
  output logic [31:0]             if_inst,
  output logic [31:0]             if_pc,
  output logic                    fetch_fault
);

  fetch_state_t state_reg, state_next;

  logic        pend_valid_reg, pend_valid_next;
  logic        pend_exc_reg, pend_exc_next;
  logic [31:0] pend_pc_reg, pend_pc_next;

  logic        buf_load, buf_clear, buf_valid;
  logic [31:0] buf_inst, buf_pc;

  logic [31:0] pc_next_c;
  logic        pc_cont_c, req_c, if_valid_c;
  logic [31:0] if_inst_c, if_pc_c;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             timeout_hit;
  logic             fault_c;
  assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES));
`endif

  ppl_fetch_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (buf_load),
    .clear   (buf_clear),
    .inst_in (imem.imem_rdata),
    .pc_in   (pc_cur),
    .valid   (buf_valid),
    .inst    (buf_inst),
    .pc      (buf_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_BOOT;
      pend_valid_reg <= 1'b0;
      pend_exc_reg   <= 1'b0;
      pend_pc_reg    <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pend_valid_next;
      pend_exc_reg   <= pend_exc_next;
      pend_pc_reg    <= pend_pc_next;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_reg   <= wait_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    pend_valid_next = pend_valid_reg;
    pend_exc_next   = pend_exc_reg;
    pend_pc_next    = pend_pc_reg;
    pc_next_c       = pc_cur;
    pc_cont_c       = 1'b0;
    req_c           = 1'b0;
    if_valid_c      = 1'b0;
    if_inst_c       = '0;
    if_pc_c         = '0;
    buf_load        = 1'b0;
    buf_clear       = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_next   = '0;
    fault_c         = 1'b0;
`endif

    unique case (state_reg)
      S_BOOT: begin
        pc_cont_c  = 1'b1;
        pc_next_c  = pc_inc(pc_cur);
        state_next = S_FETCH;
      end

      S_FETCH: begin
        req_c = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        if (timeout_hit) begin
          // Abort the stuck access and vector to the fault handler.
          req_c           = 1'b0;
          fault_c         = 1'b1;
          pc_cont_c       = 1'b1;
          pc_next_c       = EXC_VEC;
          pend_valid_next = 1'b0;
          pend_exc_next   = 1'b0;
        end else
`endif
        if (!imem.imem_ack) begin
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_next = wait_cnt_reg + 1'b1;
`endif
          // Remember the target so the in-flight word is killed on ack.
          if (exc_valid) begin
            pend_valid_next = 1'b1;
            pend_exc_next   = 1'b1;
            pend_pc_next    = EXC_VEC;
          end else if (redirect_valid && !pend_exc_reg) begin
            pend_valid_next = 1'b1;
            pend_exc_next   = 1'b0;
            pend_pc_next    = redirect_pc;
          end
        end else if (pend_valid_reg || redirect_valid || exc_valid) begin
          pc_cont_c       = 1'b1;
          pend_valid_next = 1'b0;
          pend_exc_next   = 1'b0;
          if (exc_valid)
            pc_next_c = EXC_VEC;
          else if (redirect_valid && !pend_exc_reg)
            pc_next_c = redirect_pc;
          else
            pc_next_c = pend_pc_reg;
        end else if (!stall_d) begin
          if_valid_c = 1'b1;
          if_inst_c  = imem.imem_rdata;
          if_pc_c    = pc_cur;
          pc_cont_c  = 1'b1;
          pc_next_c  = pc_inc(pc_cur);
        end else begin
          buf_load   = 1'b1;
          state_next = S_HOLD;
        end
      end

      S_HOLD: begin
        if_valid_c = buf_valid;
        if_inst_c  = buf_inst;
        if_pc_c    = buf_pc;
        if (exc_valid || redirect_valid) begin
          if_valid_c = 1'b0;
          if_inst_c  = '0;
          if_pc_c    = '0;
          buf_clear  = 1'b1;
          pc_cont_c  = 1'b1;
          pc_next_c  = exc_valid ? EXC_VEC : redirect_pc;
          state_next = S_FETCH;
        end else if (!stall_d) begin
          buf_clear  = 1'b1;
          pc_cont_c  = 1'b1;
          pc_next_c  = pc_inc(pc_cur);
          state_next = S_FETCH;
        end
      end

      default: state_next = S_BOOT;
    endcase
  end

  // Reset gates every output so imem_req drops without waiting for a clock.
  assign pc_continue    = reset & pc_cont_c;
  assign pc_next        = reset ? pc_next_c : '0;
  assign imem.imem_req  = reset & req_c;
  assign imem.imem_addr = (reset && req_c) ? pc_cur : '0;
  assign if_valid       = reset & if_valid_c;
  assign if_inst        = reset ? if_inst_c : '0;
  assign if_pc          = reset ? if_pc_c : '0;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault    = reset & fault_c;
`else
  assign fetch_fault    = 1'b0;
`endif

endmodule
